// File: rtl/serial_alu.sv
// Bit-serial ALU: operands are rotated NSHIFT bits per cycle through an external register file.
// Define SERIAL_ALU_WIDE_EN to honour the wide input (16-bit register-pair operations).
module serial_alu #(
    parameter int LOG2_NR  = 4,
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [2:0]                              op,
    input  logic [LOG2_NR-1:0]                      dst,
    input  logic [LOG2_NR-1:0]                      src,
    input  logic                                    wide,
    output logic                                    ready,
    output logic                                    done,
    output logic [3:0]                              flags,
    output logic [LOG2_NR-1:0]                      reg_index,
    output logic [LOG2_NR-1:0]                      reg_index2,
    output logic                                    do_scan,
    output logic                                    do_scan2,
    output logic [NSHIFT-1:0]                       scan_in,
    output logic [NSHIFT-1:0]                       scan_in2,
    input  logic [NSHIFT-1:0]                       scan_out,
    input  logic [NSHIFT-1:0]                       scan_out2,
    output logic [$clog2(2*REG_BITS/NSHIFT)-1:0]    bit_index
);

    localparam int N  = REG_BITS / NSHIFT;
    localparam int BW = $clog2(2 * REG_BITS / NSHIFT);

    localparam logic [BW-1:0] IDX_ZERO    = {BW{1'b0}};
    localparam logic [BW-1:0] IDX_ONE     = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] IDX_HALF    = BW'(N);
    localparam logic [BW-1:0] LAST_NARROW = BW'(N - 1);
    localparam logic [BW-1:0] LAST_WIDE   = BW'(2 * N - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_ADC = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [LOG2_NR-1:0] dst_q;
    logic [LOG2_NR-1:0] src_q;
    logic               wide_q;
    logic [BW-1:0]      bit_index_q;
    logic               carry_q;
    logic               z_acc_q;
    logic [3:0]         flags_q;
    logic               ready_q;
    logic               done_q;
    logic               do_scan_q;

    logic               wide_sel_s;
    logic               is_sub_s;
    logic               is_arith_s;
    logic               cin0_s;
    logic               cin_s;
    logic [NSHIFT-1:0]  b_s;
    logic [NSHIFT:0]    sum_s;
    logic [NSHIFT-1:0]  result_s;
    logic               cout_s;
    logic               cmsb_s;
    logic               zero_s;
    logic               last_s;
    logic               high_s;
    logic [3:0]         flags_d;

`ifdef SERIAL_ALU_WIDE_EN
    assign wide_sel_s = wide;
`else
    logic unused_wide_s;
    assign unused_wide_s = wide;
    assign wide_sel_s    = 1'b0;
`endif

    // Chunk datapath: one NSHIFT-bit slice of the result plus the flag terms it contributes.
    always_comb begin
        is_sub_s   = (op_q == OP_SUB) || (op_q == OP_SBC);
        is_arith_s = ~op_q[2];
        b_s        = is_sub_s ? ~scan_out2 : scan_out2;
        case (op_q)
            OP_ADD:         cin0_s = 1'b0;
            OP_SUB:         cin0_s = 1'b1;
            OP_ADC, OP_SBC: cin0_s = flags_q[0];
            default:        cin0_s = 1'b0;
        endcase
        if (bit_index_q == IDX_ZERO) begin
            cin_s = cin0_s;
        end else begin
            cin_s = carry_q;
        end
        sum_s = {1'b0, scan_out} + {1'b0, b_s} + {{NSHIFT{1'b0}}, cin_s};
        case (op_q)
            OP_AND:  result_s = scan_out & scan_out2;
            OP_OR:   result_s = scan_out | scan_out2;
            OP_XOR:  result_s = scan_out ^ scan_out2;
            OP_MOV:  result_s = scan_out2;
            default: result_s = sum_s[NSHIFT-1:0];
        endcase
        cout_s = sum_s[NSHIFT];
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        cmsb_s = result_s[NSHIFT-1] ^ scan_out[NSHIFT-1] ^ b_s[NSHIFT-1];
        zero_s = (result_s == {NSHIFT{1'b0}});
        last_s = (bit_index_q == (wide_q ? LAST_WIDE : LAST_NARROW));
        high_s = wide_q && (bit_index_q >= IDX_HALF);
        flags_d[3] = is_arith_s ? (cmsb_s ^ cout_s) : flags_q[3];
        flags_d[2] = result_s[NSHIFT-1];
        flags_d[1] = z_acc_q & zero_s;
        flags_d[0] = is_arith_s ? cout_s : flags_q[0];
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            dst_q       <= {LOG2_NR{1'b0}};
            src_q       <= {LOG2_NR{1'b0}};
            wide_q      <= 1'b0;
            bit_index_q <= IDX_ZERO;
            carry_q     <= 1'b0;
            z_acc_q     <= 1'b1;
            flags_q     <= 4'd0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            do_scan_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        op_q        <= op;
                        dst_q       <= dst;
                        src_q       <= src;
                        wide_q      <= wide_sel_s;
                        bit_index_q <= IDX_ZERO;
                        z_acc_q     <= 1'b1;
                        ready_q     <= 1'b0;
                        do_scan_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    carry_q <= cout_s;
                    z_acc_q <= z_acc_q & zero_s;
                    if (last_s) begin
                        state_q     <= ST_DONE;
                        bit_index_q <= IDX_ZERO;
                        flags_q     <= flags_d;
                        do_scan_q   <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        bit_index_q <= bit_index_q + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    bit_index_q <= IDX_ZERO;
                    done_q      <= 1'b0;
                    ready_q     <= 1'b1;
                    do_scan_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign flags      = flags_q;
    assign do_scan    = do_scan_q;
    assign do_scan2   = do_scan_q;
    assign bit_index  = bit_index_q;
    assign reg_index  = wide_q ? {dst_q[LOG2_NR-1:1], high_s} : dst_q;
    assign reg_index2 = wide_q ? {src_q[LOG2_NR-1:1], high_s} : src_q;
    assign scan_in    = result_s;
    assign scan_in2   = scan_out2;

endmodule
